// File: rtl/queue_pkg.sv
// rtl/queue_pkg.sv - shared constants, depth helper and status bundle for the level queue
// Purpose : default geometry of queue_level_fifo, depth function, status record type.
// Contents: DEFAULT_DATA_WIDTH, DEFAULT_ADDR_WIDTH, queue_depth(), queue_status_t.
package queue_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 4;

  // Number of entries addressed by addr_width bits.
  function automatic int unsigned queue_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  // Flag group as seen by a monitor; not driven by the RTL itself.
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } queue_status_t;

endpackage

// File: rtl/queue_mag_compare.sv
// rtl/queue_mag_compare.sv - unsigned magnitude comparator
// Purpose : compares two unsigned operands of Width bits.
// Ports   : i_a, i_b (operands); o_gt (a>b), o_lt (a<b), o_eq (a==b).
module queue_mag_compare #(
  parameter int Width = 4
) (
  input  logic [Width-1:0] i_a,
  input  logic [Width-1:0] i_b,
  output logic             o_gt,
  output logic             o_lt,
  output logic             o_eq
);

  assign o_gt = (i_a > i_b);
  assign o_lt = (i_a < i_b);
  assign o_eq = (i_a == i_b);

endmodule

// File: rtl/queue_level_fifo.sv
// rtl/queue_level_fifo.sv - circular queue with occupancy count, watermarks and error pulses
// Purpose : single-clock queue, 2^AddrWidth x DataWidth, registered read data.
// Ports   : clk, rst_n (async active-low); WrEn/DataIn write side; RdEn/DataOut read side;
//           Full, Empty, Count status; AfThresh/AeThresh watermark inputs with
//           AlmostFull/AlmostEmpty outputs; Overflow/Underflow one-cycle error pulses.
// Macro   : QUEUE_WATERMARK_EN enables the watermark comparators; otherwise
//           AlmostFull/AlmostEmpty are tied low and the thresholds are ignored.
module queue_level_fifo
  import queue_pkg::*;
#(
  parameter int DataWidth = DEFAULT_DATA_WIDTH,
  parameter int AddrWidth = DEFAULT_ADDR_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 WrEn,
  input  logic [DataWidth-1:0] DataIn,
  input  logic                 RdEn,
  output logic [DataWidth-1:0] DataOut,
  output logic                 Full,
  output logic                 Empty,
  output logic [AddrWidth:0]   Count,
  input  logic [AddrWidth:0]   AfThresh,
  input  logic [AddrWidth:0]   AeThresh,
  output logic                 AlmostFull,
  output logic                 AlmostEmpty,
  output logic                 Overflow,
  output logic                 Underflow
);

  localparam int Depth = int'(queue_depth(AddrWidth));
  localparam logic [AddrWidth:0] PtrOne = 1;

  logic [DataWidth-1:0] r_mem [0:Depth-1];
  logic [AddrWidth:0]   r_wr_ptr;
  logic [AddrWidth:0]   r_rd_ptr;
  logic [AddrWidth:0]   r_count;
  logic [DataWidth-1:0] r_data_out;
  logic                 r_overflow;
  logic                 r_underflow;

  logic w_addr_eq;
  logic w_unused_addr_gt;
  logic w_unused_addr_lt;
  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;

  queue_mag_compare #(.Width(AddrWidth)) u_addr_cmp (
    .i_a  (r_wr_ptr[AddrWidth-1:0]),
    .i_b  (r_rd_ptr[AddrWidth-1:0]),
    .o_gt (w_unused_addr_gt),
    .o_lt (w_unused_addr_lt),
    .o_eq (w_addr_eq)
  );

  // Same address: wrap bits equal means empty, different means one lap ahead (full).
  assign w_empty  = w_addr_eq && (r_wr_ptr[AddrWidth] == r_rd_ptr[AddrWidth]);
  assign w_full   = w_addr_eq && (r_wr_ptr[AddrWidth] != r_rd_ptr[AddrWidth]);

  // Acceptance uses pre-edge flags only, so a read never frees a slot for a
  // same-cycle write and a write never falls through to a same-cycle read.
  assign w_wr_acc = WrEn && !w_full;
  assign w_rd_acc = RdEn && !w_empty;

  // Storage is not reset; reset only discards contents logically via the pointers.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr[AddrWidth-1:0]] <= DataIn;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_data_out  <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= WrEn && w_full;
      r_underflow <= RdEn && w_empty;
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + PtrOne;
      end
      if (w_rd_acc) begin
        r_rd_ptr   <= r_rd_ptr + PtrOne;
        r_data_out <= r_mem[r_rd_ptr[AddrWidth-1:0]];
      end
      if (w_wr_acc && !w_rd_acc) begin
        r_count <= r_count + PtrOne;
      end else if (!w_wr_acc && w_rd_acc) begin
        r_count <= r_count - PtrOne;
      end
    end
  end

  assign DataOut   = r_data_out;
  assign Full      = w_full;
  assign Empty     = w_empty;
  assign Count     = r_count;
  assign Overflow  = r_overflow;
  assign Underflow = r_underflow;

`ifdef QUEUE_WATERMARK_EN
  logic w_af_lt;
  logic w_ae_gt;
  logic w_unused_af_gt;
  logic w_unused_af_eq;
  logic w_unused_ae_lt;
  logic w_unused_ae_eq;

  // Count >= AfThresh is !(Count < AfThresh); a zero threshold is therefore always met.
  queue_mag_compare #(.Width(AddrWidth + 1)) u_af_cmp (
    .i_a  (r_count),
    .i_b  (AfThresh),
    .o_gt (w_unused_af_gt),
    .o_lt (w_af_lt),
    .o_eq (w_unused_af_eq)
  );

  // Count <= AeThresh is !(Count > AeThresh); thresholds >= depth are always met.
  queue_mag_compare #(.Width(AddrWidth + 1)) u_ae_cmp (
    .i_a  (r_count),
    .i_b  (AeThresh),
    .o_gt (w_ae_gt),
    .o_lt (w_unused_ae_lt),
    .o_eq (w_unused_ae_eq)
  );

  assign AlmostFull  = !w_af_lt;
  assign AlmostEmpty = !w_ae_gt;
`else
  logic w_unused_thresh;
  assign w_unused_thresh = ^{AfThresh, AeThresh};
  assign AlmostFull      = 1'b0;
  assign AlmostEmpty     = 1'b0;
`endif

endmodule

// File: tb/tb_queue_level_fifo.sv
// tb/tb_queue_level_fifo.sv - directed table-driven bench for queue_level_fifo
module tb_queue_level_fifo;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] data_in;
  logic       rd_en;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic [4:0] af_thresh;
  logic [4:0] ae_thresh;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow;
  logic       underflow;

  int errors = 0;
  int checks = 0;

  queue_level_fifo #(.DataWidth(8), .AddrWidth(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .WrEn        (wr_en),
    .DataIn      (data_in),
    .RdEn        (rd_en),
    .DataOut     (data_out),
    .Full        (full),
    .Empty       (empty),
    .Count       (count),
    .AfThresh    (af_thresh),
    .AeThresh    (ae_thresh),
    .AlmostFull  (almost_full),
    .AlmostEmpty (almost_empty),
    .Overflow    (overflow),
    .Underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [7:0] din;
    logic       rd;
    logic [4:0] af;
    logic [4:0] ae;
    int         cnt;
    logic       full;
    logic       empty;
    logic [7:0] dout;
    logic       ov;
    logic       un;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic wr, input logic [7:0] din, input logic rd,
                              input logic [4:0] af, input logic [4:0] ae, input int cnt,
                              input logic f, input logic e, input logic [7:0] dout,
                              input logic ov, input logic un);
    vec_t v;
    v.wr = wr; v.din = din; v.rd = rd; v.af = af; v.ae = ae; v.cnt = cnt;
    v.full = f; v.empty = e; v.dout = dout; v.ov = ov; v.un = un;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got 0x%0h, want 0x%0h", name, idx, act, exp);
    end
  endtask

  // Watermark outputs expected for a given count and thresholds.
  function automatic logic exp_af(input int cnt, input logic [4:0] th);
`ifdef QUEUE_WATERMARK_EN
    return cnt >= int'(th);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic exp_ae(input int cnt, input logic [4:0] th);
`ifdef QUEUE_WATERMARK_EN
    return cnt <= int'(th);
`else
    return 1'b0;
`endif
  endfunction

  task automatic drive(input logic wr, input logic [7:0] din, input logic rd);
    wr_en = wr; data_in = din; rd_en = rd;
    @(negedge clk);
  endtask

  logic [7:0] model[$];
  logic [7:0] head;

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = 8'h00;
    af_thresh = 5'd12; ae_thresh = 5'd3;

    // Fill: 0x11..0x1F then 0x10; count and Full follow each write.
    for (int i = 0; i < 16; i++)
      add(1, 8'(8'h10 + (i + 1) % 16), 0, 12, 3, i + 1, i == 15, 0, 8'h00, 0, 0);
    add(1, 8'hAA, 0, 12, 3, 16, 1, 0, 8'h00, 1, 0);   // rejected 17th write
    add(0, 8'h00, 0, 12, 3, 16, 1, 0, 8'h00, 0, 0);   // Overflow lasts one cycle
    for (int j = 0; j < 16; j++)
      add(0, 8'h00, 1, 12, 3, 15 - j, 0, j == 15, 8'(8'h10 + (j + 1) % 16), 0, 0);
    add(0, 8'h00, 1, 12, 3, 0, 0, 1, 8'h10, 0, 1);    // rejected 17th read, data holds
    add(0, 8'h00, 0, 12, 3, 0, 0, 1, 8'h10, 0, 0);
    add(1, 8'h55, 1, 12, 3, 1, 0, 0, 8'h10, 0, 1);    // both on empty: write only
    add(0, 8'h00, 1, 12, 3, 0, 0, 1, 8'h55, 0, 0);
    add(0, 8'h00, 0, 0, 31, 0, 0, 1, 8'h55, 0, 0);    // zero AF / over-depth AE thresholds
    add(0, 8'h00, 0, 12, 3, 0, 0, 1, 8'h55, 0, 0);

    #12;
    check("rst_count", 0, 32'(count), 0);
    check("rst_empty", 0, 32'(empty), 1);
    check("rst_full", 0, 32'(full), 0);
    check("rst_dout", 0, 32'(data_out), 0);
    check("rst_ov_un", 0, 32'({overflow, underflow}), 0);
    check("rst_ae", 0, 32'(almost_empty), 32'(exp_ae(0, 5'd3)));
    check("rst_af", 0, 32'(almost_full), 32'(exp_af(0, 5'd12)));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < vecs.size(); k++) begin
      af_thresh = vecs[k].af; ae_thresh = vecs[k].ae;
      drive(vecs[k].wr, vecs[k].din, vecs[k].rd);
      check("count", k, 32'(count), 32'(vecs[k].cnt));
      check("full", k, 32'(full), 32'(vecs[k].full));
      check("empty", k, 32'(empty), 32'(vecs[k].empty));
      check("dout", k, 32'(data_out), 32'(vecs[k].dout));
      check("overflow", k, 32'(overflow), 32'(vecs[k].ov));
      check("underflow", k, 32'(underflow), 32'(vecs[k].un));
      check("almost_full", k, 32'(almost_full), 32'(exp_af(vecs[k].cnt, vecs[k].af)));
      check("almost_empty", k, 32'(almost_empty), 32'(exp_ae(vecs[k].cnt, vecs[k].ae)));
    end

    // Steady state at Count=5 with simultaneous traffic; order must be preserved.
    for (int k = 0; k < 5; k++) begin
      drive(1, 8'(8'h30 + k), 0);
      model.push_back(8'(8'h30 + k));
    end
    check("pre_steady_count", 0, 32'(count), 5);
    for (int c = 0; c < 40; c++) begin
      drive(1, 8'(8'h40 + c), 1);
      head = model.pop_front();
      model.push_back(8'(8'h40 + c));
      check("steady_dout", c, 32'(data_out), 32'(head));
      check("steady_count", c, 32'(count), 5);
    end
    for (int k = 0; k < 5; k++) begin
      drive(0, 8'h00, 1);
      head = model.pop_front();
      check("drain_dout", k, 32'(data_out), 32'(head));
    end
    check("drain_empty", 0, 32'(empty), 1);

    // Both requests while full: read accepted, write rejected.
    for (int k = 0; k < 16; k++) drive(1, 8'(8'h60 + k), 0);
    check("fill_full", 0, 32'(full), 1);
    drive(1, 8'hEE, 1);
    check("fullrw_count", 0, 32'(count), 15);
    check("fullrw_ov", 0, 32'(overflow), 1);
    check("fullrw_dout", 0, 32'(data_out), 32'h60);
    check("fullrw_full", 0, 32'(full), 0);
    drive(0, 8'h00, 0);
    check("fullrw_ov_end", 0, 32'(overflow), 0);

    // Asynchronous reset mid-stream at Count=9, then fresh data must come back.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 9; k++) drive(1, 8'(8'h80 + k), 0);
    check("pre_rst_count", 0, 32'(count), 9);
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", 0, 32'(count), 0);
    check("arst_empty", 0, 32'(empty), 1);
    check("arst_dout", 0, 32'(data_out), 0);
    check("arst_full", 0, 32'(full), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 8'h99, 0);
    drive(0, 8'h00, 1);
    check("post_rst_dout", 0, 32'(data_out), 32'h99);
    check("post_rst_count", 0, 32'(count), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
